// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared constants for the wb_timer peripheral.
//   - register offsets as decoded from wb_adr_i[4:2]
//   - CTRL / STATUS bit positions
//   - prescaler width and a byte-lane merge helper for Wishbone writes
package wb_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_RELOAD   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STATUS_EXP  = 0;

  localparam int PRESCALE_W = 16;

  // Replace only the byte lanes enabled in sel with the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_core.sv
// wb_timer_core: prescaler, 32-bit down-counter and EXP/EN state.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   auto_i                   reload from reload_i on expiry instead of stopping
//   prescale_i, reload_i     current PRESCALE / RELOAD register values
//   en_wr_i, en_wdata_i      bus write of CTRL.EN and the value written
//   count_wr_i, count_wdata_i bus write of COUNT (already byte-merged)
//   exp_clr_i                write-1-to-clear of STATUS.EXP
//   en_o, count_o, exp_o     register state for readback / irq
module wb_timer_core
  import wb_timer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  auto_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [31:0]           reload_i,
  input  logic                  en_wr_i,
  input  logic                  en_wdata_i,
  input  logic                  count_wr_i,
  input  logic [31:0]           count_wdata_i,
  input  logic                  exp_clr_i,
  output logic                  en_o,
  output logic [31:0]           count_o,
  output logic                  exp_o
);

  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic [31:0]           count_q, count_d;
  logic                  en_q, en_d;
  logic                  exp_q, exp_d;
  logic                  tick;
  logic                  expire;

  always_comb begin
    tick   = en_q && (pc_q == prescale_i);
    expire = tick && (count_q == 32'd0);

    // A CTRL write that sets EN restarts the prescale phase even if already running.
    pc_d = pc_q + 16'd1;
    if (!en_q || (en_wr_i && en_wdata_i) || tick) pc_d = '0;

    count_d = count_q;
    if (count_wr_i) begin
      count_d = count_wdata_i;
    end else if (tick) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (auto_i)      count_d = reload_i;
    end

    exp_d = exp_q;
    if (expire)         exp_d = 1'b1;
    else if (exp_clr_i) exp_d = 1'b0;

    // One-shot expiry stopping the timer wins over a simultaneous software enable.
    en_d = en_q;
    if (expire && !auto_i) en_d = 1'b0;
    else if (en_wr_i)      en_d = en_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      en_q    <= en_d;
      exp_q   <= exp_d;
    end
  end

  assign en_o    = en_q;
  assign count_o = count_q;
  assign exp_o   = exp_q;

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic slave with one 32-bit down-counting timer,
// 16-bit prescaler, auto-reload and a level interrupt.
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-low reset
//   wb_adr_i                  byte address, only [4:2] decoded
//   wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i  bus request
//   wb_cti_i                  ignored, all accesses are classic
//   wb_dat_o, wb_ack_o        registered read data / one-cycle acknowledge
//   irq                       EXP & IRQ_EN, straight from registers
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [31:0]           RESET_RELOAD   = 32'h0000_0000,
  parameter logic [PRESCALE_W-1:0] RESET_PRESCALE = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        irq
);

  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  auto_q, auto_d;
  logic                  irq_en_q, irq_en_d;
  logic [31:0]           reload_q, reload_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic                  access;
  logic                  wr;
  logic [2:0]            off;
  logic                  ctrl_wr;
  logic                  count_wr;
  logic [31:0]           count_wdata;
  logic                  exp_clr;
  logic [31:0]           rdata;

  logic                  en;
  logic [31:0]           count;
  logic                  exp_flag;

  logic                  unused_bus_bits;
  assign unused_bus_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_cti_i};

  // The edge that raises ack is the one that commits the access.
  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign off    = wb_adr_i[4:2];

  // All CTRL/STATUS bits sit in byte lane 0.
  assign ctrl_wr     = wr && (off == REG_CTRL) && wb_sel_i[0];
  assign exp_clr     = wr && (off == REG_STATUS) && wb_sel_i[0] && wb_dat_i[STATUS_EXP];
  // sel==0 must not freeze the counter, so require at least one lane.
  assign count_wr    = wr && (off == REG_COUNT) && (|wb_sel_i);
  assign count_wdata = merge_bytes(count, wb_dat_i, wb_sel_i);

  always_comb begin
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    if (ctrl_wr) begin
      auto_d   = wb_dat_i[CTRL_AUTO];
      irq_en_d = wb_dat_i[CTRL_IRQ_EN];
    end
    if (wr && (off == REG_RELOAD)) reload_d = merge_bytes(reload_q, wb_dat_i, wb_sel_i);
    if (wr && (off == REG_PRESCALE)) begin
      if (wb_sel_i[0]) prescale_d[7:0]  = wb_dat_i[7:0];
      if (wb_sel_i[1]) prescale_d[15:8] = wb_dat_i[15:8];
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_EN]     = en;
        rdata[CTRL_AUTO]   = auto_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_RELOAD:   rdata = reload_q;
      REG_COUNT:    rdata = count;
      REG_STATUS:   rdata[STATUS_EXP] = exp_flag;
      REG_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q;
      default:      rdata = '0;
    endcase
  end

  assign ack_d = access;
  assign dat_d = access ? rdata : 32'd0;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      reload_q   <= RESET_RELOAD;
      prescale_q <= RESET_PRESCALE;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
    end
  end

  wb_timer_core u_core (
    .clk_i        (sys_clk),
    .rst_ni       (sys_rst),
    .auto_i       (auto_q),
    .prescale_i   (prescale_q),
    .reload_i     (reload_q),
    .en_wr_i      (ctrl_wr),
    .en_wdata_i   (wb_dat_i[CTRL_EN]),
    .count_wr_i   (count_wr),
    .count_wdata_i(count_wdata),
    .exp_clr_i    (exp_clr),
    .en_o         (en),
    .count_o      (count),
    .exp_o        (exp_flag)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = exp_flag & irq_en_q;

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic [2:0]  wb_cti_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;
  int edge_n = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  wb_timer dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got run still active want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One classic access. tgt != 0 requests that the ack-raising edge be edge number tgt.
  task automatic xfer(input logic we, input logic [2:0] off, input logic [31:0] wd,
                      input logic [3:0] sel, input int tgt,
                      output logic [31:0] rd, output int acc_edge);
    int g;
    g = 0;
    @(negedge sys_clk);
    while (tgt != 0 && edge_n + 1 < tgt && g < 500) begin
      @(negedge sys_clk);
      g++;
    end
    if (tgt != 0) chk("sched", 32'(edge_n + 1), 32'(tgt));
    wb_adr_i = {27'd0, off, 2'b00};
    wb_dat_i = wd;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cti_i = 3'($urandom_range(0, 7));
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(negedge sys_clk);
    chk("ack", {31'd0, wb_ack_o}, 32'd1);
    rd       = wb_dat_o;
    acc_edge = edge_n;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel,
                    input int tgt, output int acc_edge);
    logic [31:0] rd;
    xfer(1'b1, off, d, sel, tgt, rd, acc_edge);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] want,
                        input int tgt);
    logic [31:0] rd;
    int          e;
    sb_t         s;
    sb_q.push_back('{tag: tag, val: want});
    xfer(1'b0, off, 32'd0, 4'hF, tgt, rd, e);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      s = sb_q.pop_front();
      chk(s.tag, rd, s.val);
    end
  endtask

  initial begin
    int e0;
    int e1;
    int e2;
    int d;

    repeat (3) @(negedge sys_clk);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    sys_rst = 1'b1;

    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), 3'(i), 32'd0, 0);

    // Held strobe: ack on every second edge.
    @(negedge sys_clk);
    wb_adr_i = {27'd0, 3'd1, 2'b00};
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk($sformatf("held_ack%0d", i), {31'd0, wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("idle_ack", {31'd0, wb_ack_o}, 32'd0);

    // Byte lanes and unmapped offset.
    wr(3'd1, 32'hAABB_CCDD, 4'b0101, 0, d);
    rd_chk("reload_sel", 3'd1, 32'h00BB_00DD, 0);
    wr(3'd6, 32'hFFFF_FFFF, 4'hF, 0, d);
    rd_chk("unmapped6", 3'd6, 32'd0, 0);

    // One-shot: expiry 6 edges after the enabling write.
    wr(3'd4, 32'd1, 4'hF, 0, d);
    wr(3'd2, 32'd2, 4'hF, 0, d);
    wr(3'd0, 32'h5, 4'hF, 0, e0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge sys_clk);
      chk($sformatf("oneshot_irq%0d", k), {31'd0, irq}, (k >= 6) ? 32'd1 : 32'd0);
    end
    rd_chk("oneshot_status", 3'd3, 32'd1, 0);
    rd_chk("oneshot_ctrl", 3'd0, 32'd4, 0);
    rd_chk("oneshot_count", 3'd2, 32'd0, 0);
    repeat (10) @(negedge sys_clk);
    rd_chk("oneshot_hold", 3'd2, 32'd0, 0);

    // Auto-reload: RELOAD=3, PRESCALE=0; count after edge e0+j is 3-((j-1)%4).
    wr(3'd3, 32'd1, 4'hF, 0, d);
    rd_chk("w1c_status", 3'd3, 32'd0, 0);
    wr(3'd0, 32'd0, 4'hF, 0, d);
    wr(3'd4, 32'd0, 4'hF, 0, d);
    wr(3'd1, 32'd3, 4'hF, 0, d);
    wr(3'd2, 32'd0, 4'hF, 0, d);
    wr(3'd0, 32'h3, 4'hF, 0, e0);
    rd_chk("auto_cnt0", 3'd2, 32'd3, e0 + 2);
    rd_chk("auto_cnt1", 3'd2, 32'd2, e0 + 7);
    rd_chk("auto_cnt2", 3'd2, 32'd1, e0 + 12);
    rd_chk("auto_cnt3", 3'd2, 32'd0, e0 + 17);
    rd_chk("auto_cnt4", 3'd2, 32'd3, e0 + 22);

    // W1C on an expiry edge (e0+25) loses; off-expiry (e0+31) wins.
    wr(3'd3, 32'd1, 4'hF, e0 + 25, d);
    rd_chk("w1c_vs_exp", 3'd3, 32'd1, 0);
    wr(3'd3, 32'd1, 4'hF, e0 + 31, d);
    rd_chk("w1c_clear", 3'd3, 32'd0, 0);
    rd_chk("exp_again", 3'd3, 32'd1, e0 + 35);

    // COUNT write on a tick edge: PRESCALE=3, first tick at e1+4.
    wr(3'd0, 32'd0, 4'hF, 0, d);
    wr(3'd4, 32'd3, 4'hF, 0, d);
    wr(3'd2, 32'd10, 4'hF, 0, d);
    wr(3'd0, 32'h1, 4'hF, 0, e1);
    wr(3'd2, 32'h0000_1234, 4'hF, e1 + 4, d);
    rd_chk("cnt_wr_tick", 3'd2, 32'h0000_1234, 0);

    // Reset mid-operation with EXP still set and ack high.
    wr(3'd4, 32'h0000_FFFF, 4'hF, 0, d);
    wr(3'd2, 32'd100, 4'hF, 0, d);
    wr(3'd0, 32'h5, 4'hF, 0, d);
    @(negedge sys_clk);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    wb_adr_i = {27'd0, 3'd2, 2'b00};
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(negedge sys_clk);
    chk("pre_rst_ack", {31'd0, wb_ack_o}, 32'd1);
    chk("pre_rst_dat", wb_dat_o, 32'd100);
    #2 sys_rst = 1'b0;
    #1;
    chk("async_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("async_dat", wb_dat_o, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rd_chk("post_rst_ctrl", 3'd0, 32'd0, 0);
    rd_chk("post_rst_count", 3'd2, 32'd0, 0);
    rd_chk("post_rst_status", 3'd3, 32'd0, 0);
    rd_chk("post_rst_presc", 3'd4, 32'd0, 0);
    wr(3'd2, 32'd5, 4'hF, 0, d);
    repeat (8) @(negedge sys_clk);
    rd_chk("post_rst_idle", 3'd2, 32'd5, 0);
    wr(3'd0, 32'h1, 4'hF, 0, e2);
    rd_chk("post_rst_run", 3'd2, 32'd4, e2 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
